mul_writeback_unit: RTL

Sequential shift-add multiplier sitting between the register file's read ports and its write-back port. It accepts two operands plus a destination register address, computes the 2·DATA_WIDTH-bit unsigned product over DATA_WIDTH iterations, and writes either the low or high half back through a one-cycle write pulse. Its write-back outputs connect directly to the register file's `wr_addr` / `wr_data` / `wr_enable`.

---
 rtl/mul_pkg.sv | 11 +
 rtl/mul_writeback_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier write-back unit.
//   mul_state_t : FSM encoding (IDLE, RUN, WB)
//   MUL_LO/HI   : values of in_high selecting the low (MUL) or high (MULHU) half
package mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, WB} mul_state_t;

    localparam logic MUL_LO = 1'b0;
    localparam logic MUL_HI = 1'b1;

endpackage

// File: rtl/mul_writeback_unit.sv
// Shift-add unsigned multiplier between the register file read ports and its
// write-back port. One iteration per cycle for DATA_WIDTH cycles, then a single
// write pulse carrying the selected half of the 2*DATA_WIDTH-bit product.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     command handshake (ready only in IDLE)
//   in_op_a, in_op_b      multiplicand, multiplier
//   in_high               0 = low half, 1 = high half of the product
//   in_dest               destination register
//   busy, busy_dest       in-flight indication and its destination (0 when idle)
//   wr_addr/wr_data       register file write port (hold last value when idle)
//   wr_enable             one-cycle write strobe
module mul_writeback_unit
    import mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_op_a,
    input  logic [DATA_WIDTH-1:0] in_op_b,
    input  logic                  in_high,
    input  logic [ADDR_WIDTH-1:0] in_dest,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] busy_dest,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_enable
);

    localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    mul_state_t              state_q, state_d;
    logic [PROD_WIDTH-1:0]   mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [PROD_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    high_q, high_d;
    logic [ADDR_WIDTH-1:0]   dest_q, dest_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    logic [PROD_WIDTH-1:0]   acc_sum;
    logic                    last_iter;

    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_iter = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        high_d    = high_q;
        dest_d    = dest_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{DATA_WIDTH{1'b0}}, in_op_a};
                    mplier_d = in_op_b;
                    high_d   = in_high;
                    dest_d   = in_dest;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_WIDTH'(1);
                if (last_iter) begin
                    // Result registers load on the final iteration so WB drives them directly.
                    state_d   = WB;
                    wr_addr_d = dest_q;
                    wr_data_d = (high_q == MUL_HI) ? acc_sum[PROD_WIDTH-1:DATA_WIDTH]
                                                   : acc_sum[DATA_WIDTH-1:0];
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            high_q    <= 1'b0;
            dest_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            dest_q    <= dest_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign busy_dest = busy ? dest_q : '0;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    // Reset asserted while in WB must suppress the write the register file would capture.
    assign wr_enable = (state_q == WB) && !rst;

endmodule
